// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencing controller -- load-use bubbles, branch flushes,
// memory-wait freeze with timeout, HLT latch and saturating stall counter.
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       rdReg1_ID,
    input  logic [3:0]       rdReg2_ID,
    input  logic             use1_ID,
    input  logic             use2_ID,
    input  logic [3:0]       wrReg_EX,
    input  logic             memRd_EX,
    input  logic             br_taken_EX,
    input  logic             mem_req_MEM,
    input  logic             mem_rdy,
    input  logic             hlt_WB,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN = 2'd0, MEMWAIT = 2'd1, HALT = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_q, wait_d;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memwait, lduse, timeout, frozen, any_ctl;

    assign memwait = mem_req_MEM & ~mem_rdy;
    // R0 is hardwired zero, so a load targeting it never creates a real dependency
    assign lduse   = memRd_EX & (wrReg_EX != 4'd0) &
                     ((use1_ID & (rdReg1_ID == wrReg_EX)) | (use2_ID & (rdReg2_ID == wrReg_EX)));
    assign timeout = memwait & (wait_q == WC_W'(MEM_TIMEOUT - 1));
    assign frozen  = (state_q == HALT) | memwait;

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        memwb_bubble = 1'b0;
        if (!rst_n) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (frozen) begin
            pc_hold      = 1'b1;
            ifid_hold    = 1'b1;
            idex_hold    = 1'b1;
            exmem_hold   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (br_taken_EX) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (lduse) begin
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_flush = 1'b1;
        end
    end

    assign any_ctl = pc_hold | ifid_hold | idex_hold | exmem_hold | ifid_flush | idex_flush;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        wait_d  = (memwait && state_q != HALT) ? wait_q + 1'b1 : '0;
        if (state_q != HALT) begin
            if (timeout) begin
                state_d = HALT;
                err_d   = 1'b1;
            end else if (memwait) begin
                state_d = MEMWAIT;
            end else if (hlt_WB) begin
                state_d = HALT;
            end else begin
                state_d = RUN;
            end
        end
        halted_d = halted_q | (state_d == HALT);
        cnt_d    = (any_ctl && state_q != HALT && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= RUN;
            wait_q   <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign halted    = halted_q;
    assign mem_err   = err_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed vectors with hand-computed expectations, checked by a scoreboard monitor.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] rdReg1_ID, rdReg2_ID, wrReg_EX;
    logic use1_ID, use2_ID, memRd_EX, br_taken_EX, mem_req_MEM, mem_rdy, hlt_WB;
    logic pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_bubble;
    logic halted, mem_err;
    logic [15:0] stall_cnt;
    logic pc_hold2, ifid_hold2, idex_hold2, exmem_hold2, ifid_flush2, idex_flush2, memwb_bubble2;
    logic halted2, mem_err2;
    logic [2:0] stall_cnt2;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID),
        .use1_ID(use1_ID), .use2_ID(use2_ID), .wrReg_EX(wrReg_EX), .memRd_EX(memRd_EX),
        .br_taken_EX(br_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_rdy(mem_rdy), .hlt_WB(hlt_WB),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_bubble(memwb_bubble),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt));

    // narrow counter copy exercises saturation within a short run
    pipe_ctrl #(.MEM_TIMEOUT(16), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .rdReg1_ID(rdReg1_ID), .rdReg2_ID(rdReg2_ID),
        .use1_ID(use1_ID), .use2_ID(use2_ID), .wrReg_EX(wrReg_EX), .memRd_EX(memRd_EX),
        .br_taken_EX(br_taken_EX), .mem_req_MEM(mem_req_MEM), .mem_rdy(mem_rdy), .hlt_WB(hlt_WB),
        .pc_hold(pc_hold2), .ifid_hold(ifid_hold2), .idex_hold(idex_hold2), .exmem_hold(exmem_hold2),
        .ifid_flush(ifid_flush2), .idex_flush(idex_flush2), .memwb_bubble(memwb_bubble2),
        .halted(halted2), .mem_err(mem_err2), .stall_cnt(stall_cnt2));

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] LDU  = 7'b1100010;
    localparam logic [6:0] BRC  = 7'b0000110;
    localparam logic [6:0] RSTC = 7'b0000110;
    localparam logic [6:0] FRZ  = 7'b1111001;

    typedef struct {
        string      name;
        logic [6:0] ctl;
        logic       h;
        logic       e;
        int         cnt;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check({x.name, ".ctl"}, int'({pc_hold, ifid_hold, idex_hold, exmem_hold,
                                          ifid_flush, idex_flush, memwb_bubble}), int'(x.ctl));
            check({x.name, ".halted"}, int'(halted), int'(x.h));
            check({x.name, ".mem_err"}, int'(mem_err), int'(x.e));
            check({x.name, ".stall_cnt"}, int'(stall_cnt), x.cnt);
            check({x.name, ".sat_cnt"}, int'(stall_cnt2), (x.cnt > 7) ? 7 : x.cnt);
        end
    end

    task automatic vec(input string nm, input bit rst, input bit ld, input logic [3:0] wr,
                       input bit u1, input logic [3:0] r1, input bit u2, input logic [3:0] r2,
                       input bit br, input bit mreq, input bit mrdy, input bit hlt,
                       input logic [6:0] c, input bit h, input bit e, input int cnt);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rst; memRd_EX = ld; wrReg_EX = wr; use1_ID = u1; rdReg1_ID = r1;
        use2_ID = u2; rdReg2_ID = r2; br_taken_EX = br; mem_req_MEM = mreq;
        mem_rdy = mrdy; hlt_WB = hlt;
        x.name = nm; x.ctl = c; x.h = h; x.e = e; x.cnt = cnt;
        sb.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0; memRd_EX = 1'b0; wrReg_EX = 4'd0; use1_ID = 1'b0; rdReg1_ID = 4'd0;
        use2_ID = 1'b0; rdReg2_ID = 4'd0; br_taken_EX = 1'b0; mem_req_MEM = 1'b0;
        mem_rdy = 1'b0; hlt_WB = 1'b0;
        repeat (2) @(posedge clk);
        vec("rst",        0, 0,0, 0,0, 0,0, 0,0,0,0, RSTC, 0,0, 0);
        vec("idle",       1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 0);
        vec("T1_lduse",   1, 1,3, 1,3, 0,0, 0,0,0,0, LDU,  0,0, 0);
        vec("T1_after",   1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 1);
        vec("T2_r0",      1, 1,0, 1,0, 0,0, 0,0,0,0, NONE, 0,0, 1);
        vec("T2_nouse",   1, 1,3, 0,3, 0,0, 0,0,0,0, NONE, 0,0, 1);
        vec("T2_use2",    1, 1,3, 0,0, 1,3, 0,0,0,0, LDU,  0,0, 1);
        vec("T2_noload",  1, 0,3, 1,3, 0,0, 0,0,0,0, NONE, 0,0, 2);
        for (int i = 0; i < 3; i++)
            vec("T3_wait",1, 0,0, 0,0, 0,0, 0,1,0,0, FRZ,  0,0, 2 + i);
        vec("T3_rdy",     1, 0,0, 0,0, 0,0, 0,1,1,0, NONE, 0,0, 5);
        vec("T4_br_ld",   1, 1,3, 1,3, 0,0, 1,0,0,0, BRC,  0,0, 5);
        vec("T4_wait1",   1, 1,3, 1,3, 0,0, 1,1,0,0, FRZ,  0,0, 6);
        vec("T4_wait2",   1, 1,3, 1,3, 0,0, 1,1,0,0, FRZ,  0,0, 7);
        vec("T4_rdy",     1, 1,3, 1,3, 0,0, 1,1,1,0, BRC,  0,0, 8);
        vec("T4_ldwait",  1, 1,3, 1,3, 0,0, 0,1,0,0, FRZ,  0,0, 9);
        vec("T4_ldrdy",   1, 1,3, 1,3, 0,0, 0,1,1,0, LDU,  0,0, 10);
        vec("idle2",      1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 11);
        vec("T6_hlt",     1, 0,0, 0,0, 0,0, 0,0,0,1, NONE, 0,0, 11);
        vec("T6_halt",    1, 0,0, 0,0, 0,0, 0,0,0,0, FRZ,  1,0, 11);
        vec("T6_halt_br", 1, 1,3, 1,3, 0,0, 1,0,0,0, FRZ,  1,0, 11);
        vec("T6_rst",     0, 0,0, 0,0, 0,0, 0,0,0,0, RSTC, 1,0, 11);
        vec("post_rst",   1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 0);
        vec("hlt_memwait",1, 0,0, 0,0, 0,0, 0,1,0,1, FRZ,  0,0, 0);
        vec("memwait",    1, 0,0, 0,0, 0,0, 0,1,0,0, FRZ,  0,0, 1);
        vec("rst_memwait",0, 0,0, 0,0, 0,0, 0,1,0,0, RSTC, 0,0, 2);
        vec("post_rst2",  1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 0);
        for (int i = 0; i < 15; i++)
            vec("w15_wait",1, 0,0, 0,0, 0,0, 0,1,0,0, FRZ,  0,0, i);
        vec("w15_rdy",    1, 0,0, 0,0, 0,0, 0,1,1,0, NONE, 0,0, 15);
        vec("w15_idle",   1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 15);
        for (int i = 0; i < 16; i++)
            vec("T5_wait",1, 0,0, 0,0, 0,0, 0,1,0,0, FRZ,  0,0, 15 + i);
        vec("T5_halt",    1, 0,0, 0,0, 0,0, 0,1,0,0, FRZ,  1,1, 31);
        vec("T5_rdy",     1, 0,0, 0,0, 0,0, 0,1,1,0, FRZ,  1,1, 31);
        vec("T5_rst",     0, 0,0, 0,0, 0,0, 0,0,0,0, RSTC, 1,1, 31);
        vec("T5_post",    1, 0,0, 0,0, 0,0, 0,0,0,0, NONE, 0,0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
